if_fetch_queue: RTL

IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

---
 rtl/if_fetch_queue.sv | 111 +++++++++++
 1 files changed

// File: rtl/if_fetch_queue.sv
// Instruction fetch front end: issues aligned fetch requests and buffers up to two
// in-order responses for decode, with redirect flush and stale-response dropping.
module if_fetch_queue #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [63:0] id_pc,
  output logic [31:0] id_instruction
);

  logic [63:0] fetch_pc;
  logic [1:0]  slot_alloc;
  logic [1:0]  slot_filled;
  logic [63:0] slot_pc    [2];
  logic [31:0] slot_instr [2];
  logic        head;
  logic [1:0]  drop_cnt;

  logic [1:0]  alloc_cnt;
  logic [1:0]  unfilled_cnt;
  logic [2:0]  outstanding;
  logic [1:0]  redirect_drop;
  logic        tail;
  logic        fill_idx;
  logic        head_filled;
  logic        req_fire;
  logic        deq;
  logic        rsp_drop;
  logic        rsp_fill;

  always_comb begin
    alloc_cnt    = {1'b0, slot_alloc[0]} + {1'b0, slot_alloc[1]};
    unfilled_cnt = {1'b0, slot_alloc[0] & ~slot_filled[0]}
                 + {1'b0, slot_alloc[1] & ~slot_filled[1]};
    tail         = (alloc_cnt == 2'd0) ? head : ~head;
    // Slots fill in order, so the oldest unfilled slot is the head unless it is already filled.
    fill_idx     = (slot_alloc[head] && !slot_filled[head]) ? head : ~head;
    head_filled  = slot_alloc[head] & slot_filled[head];
  end

  always_comb begin
    // Every request still in flight after a redirect must be dropped, except one landing now.
    outstanding   = {1'b0, unfilled_cnt} + {1'b0, drop_cnt};
    redirect_drop = outstanding[1:0];
    if (imem_rsp_valid && outstanding != 3'd0)
      redirect_drop = 2'(outstanding - 3'd1);
  end

  always_comb begin
    imem_req_valid = rst_n && !redirect_valid
                   && (({1'b0, alloc_cnt} + {1'b0, drop_cnt}) < 3'd2);
    imem_req_addr  = fetch_pc;
    id_valid       = rst_n && head_filled;
    id_pc          = rst_n ? slot_pc[head]    : '0;
    id_instruction = rst_n ? slot_instr[head] : '0;
    req_fire       = imem_req_valid && imem_req_ready;
    deq            = id_valid && id_ready;
    rsp_drop       = imem_rsp_valid && (drop_cnt != 2'd0);
    rsp_fill       = imem_rsp_valid && (drop_cnt == 2'd0)
                   && slot_alloc[fill_idx] && !slot_filled[fill_idx];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      slot_alloc  <= '0;
      slot_filled <= '0;
      head        <= 1'b0;
      drop_cnt    <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        slot_pc[i]    <= '0;
        slot_instr[i] <= '0;
      end
    end else if (redirect_valid) begin
      fetch_pc    <= redirect_pc & ~64'h3;
      slot_alloc  <= '0;
      slot_filled <= '0;
      drop_cnt    <= redirect_drop;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 64'd4;
      if (rsp_drop) drop_cnt <= drop_cnt - 2'd1;
      for (int unsigned i = 0; i < 2; i++) begin
        if (deq && head == 1'(i)) begin
          slot_alloc[i]  <= 1'b0;
          slot_filled[i] <= 1'b0;
        end
        if (rsp_fill && fill_idx == 1'(i)) begin
          slot_filled[i] <= 1'b1;
          slot_instr[i]  <= imem_rsp_data;
        end
        if (req_fire && tail == 1'(i)) begin
          slot_alloc[i]  <= 1'b1;
          slot_filled[i] <= 1'b0;
          slot_pc[i]     <= fetch_pc;
        end
      end
      if (deq) head <= ~head;
    end
  end

endmodule
